stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Run/pause/lap/clear controller for the stopwatch. It gates the enable of the free-running tick timer and accumulates that timer's `done` pulses into a BCD time count, MM:SS.CC, from 00:00.00 to 59:59.99. It also provides a lap-freeze display path. It sits between the debounced, single-pulsed push-button logic and the seven-segment display multiplexer.

## Interface
- `CS_PER_SEC`, default 100: centisecond wrap count. Must be 100 for the BCD output to be meaningful; exposed only to shorten simulation.
- `clk` in 1: system clock. All state changes on the rising edge.
- `reset_n` in 1: reset. Asynchronous and active-low.
- `start_stop` in 1: single-cycle pulse from the start/stop button.
- `lap` in 1: single-cycle pulse from the lap button.
- `clear` in 1: single-cycle pulse from the clear button.
- `tick` in 1: `done` of the tick timer; one cycle high per centisecond while enabled.
- `tick_en` out 1: enable to the tick timer.
- `running` out 1: high in RUN and LAP.
- `frozen` out 1: high in LAP; the display shows the captured lap time.
- `disp_bcd` out 24: display value, {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, 4 bits each.
- `overflow` out 1: sticky; set when the count saturates at 59:59.99.

## Operation
- State machine with four states: IDLE, RUN, LAP, PAUSE. Encoding is free.
- Transitions from IDLE:
  - `start_stop` -> RUN.
  - `lap` and `clear` are ignored.
- Transitions from RUN:
  - `start_stop` -> PAUSE.
  - `lap` -> LAP, and the live count is captured into the lap register in the same edge.
  - `clear` is ignored.
- Transitions from LAP:
  - `lap` -> RUN (display unfreezes).
  - `start_stop` -> PAUSE (display shows the live count).
  - `clear` is ignored.
- Transitions from PAUSE:
  - `start_stop` -> RUN.
  - `clear` -> IDLE; the count, lap register and `overflow` are zeroed.
  - `lap` is ignored.
- Simultaneous pulses: priority is `clear` > `start_stop` > `lap`. Only the highest-priority pulse that is legal in the current state acts; the others are dropped.
- `tick_en` = (state == RUN or LAP), decoded from the registered state.
- Counting:
  - A tick is counted when `tick` is high and `tick_en` is high, both sampled in the same cycle. The current state decides; a transition occurring in that cycle does not cancel the tick.
  - Since the timer holds `done` high while disabled, a tick seen with `tick_en` low is ignored.
- Counter chain:
  - cs_o increments 0..9 and carries to cs_t.
  - cs_t runs 0..9 (total CS_PER_SEC-1) and carries to sec_o.
  - sec_o runs 0..9 into sec_t; sec_t runs 0..5 into min_o.
  - min_o runs 0..9 into min_t; min_t runs 0..5.
  - All digit carries resolve in the same edge.
- Saturation at 59:59.99:
  - A counted tick leaves the count unchanged, sets `overflow`, and forces the state to PAUSE.
  - From PAUSE with `overflow` set, `start_stop` is ignored; only `clear` leaves.
- Display selection: `disp_bcd` = lap register in LAP, otherwise the live count.
- The tick timer's phase is not cleared by `clear`. The first tick after start arrives 1..FINAL_VALUE+1 cycles later, which is accepted.

## Timing
- Reset values:
  - state IDLE
  - `tick_en` 0, `running` 0, `frozen` 0
  - `disp_bcd` 24'h000000, `overflow` 0
  - lap register 0
- Button pulse at edge N: the state and its outputs change after edge N. `tick_en` rises or falls one cycle after the pulse is sampled.
- Counted tick at edge N: `disp_bcd` shows the new value after edge N (one-cycle latency). There is no combinational path from `tick` to `disp_bcd`.
- Lap capture at edge N: the value captured is the count after edge N, including any tick counted at N.
- Reset mid-operation: immediate return to reset values regardless of state. No pulse is remembered.
- All outputs are registered or decoded from registers only. No input-to-output combinational path.

## Test plan
- Reset, then `start_stop`, then 250 `tick` pulses spaced 3 cycles -> `tick_en`=1 one cycle after the pulse, `disp_bcd`=24'h000250, `running`=1.
- From 00:59.99 in RUN, one tick -> 24'h010000. From 09:59.99 -> 24'h100000.
- In RUN at 00:12.34: `lap`, then 10 ticks -> `disp_bcd` holds 24'h001234 with `frozen`=1. A second `lap` -> 24'h001244 and `frozen`=0.
- `start_stop` and `clear` in the same cycle while PAUSE at 00:05.00 -> IDLE, count 0. In RUN, `clear` alone -> no effect and counting continues.
- At 59:59.99 in RUN, one tick -> count stays 24'h595999, `overflow`=1, PAUSE, `tick_en`=0. `start_stop` is ignored; `clear` -> IDLE with `overflow`=0.
- `tick` held high while in PAUSE for 20 cycles -> count unchanged. Assert `reset_n`=0 mid-RUN -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Run/pause/lap/clear FSM with a saturating MM:SS.CC BCD counter.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int CS_PER_SEC = 100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_stop_i,
  input  logic        lap_i,
  input  logic        clear_i,
  input  logic        tick_i,
  output logic        tick_en_o,
  output logic        running_o,
  output logic        frozen_o,
  output logic [23:0] disp_bcd_o,
  output logic        overflow_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  localparam logic [3:0]  c_CS_T_MAX = 4'((CS_PER_SEC - 1) / 10);
  localparam logic [3:0]  c_CS_O_MAX = 4'((CS_PER_SEC - 1) % 10);
  localparam logic [23:0] c_CNT_MAX  = {4'd5, 4'd9, 4'd5, 4'd9, c_CS_T_MAX, c_CS_O_MAX};

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d, lap_q, lap_d;
  logic        ovf_q, ovf_d;
  logic [23:0] w_cnt_inc;
  logic        w_c_cs, w_c_so, w_c_st, w_c_mo;
  logic        w_tick_ok, w_sat;

  // Digit-serial BCD increment; every carry resolves within one edge.
  always_comb begin
    w_cnt_inc = cnt_q;
    w_c_cs    = 1'b0;
    w_c_so    = 1'b0;
    w_c_st    = 1'b0;
    w_c_mo    = 1'b0;
    if (cnt_q[7:4] == c_CS_T_MAX && cnt_q[3:0] == c_CS_O_MAX) begin
      w_cnt_inc[7:0] = 8'h00;
      w_c_cs         = 1'b1;
    end else if (cnt_q[3:0] == 4'd9) begin
      w_cnt_inc[3:0] = 4'd0;
      w_cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
    end else begin
      w_cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
    end
    if (w_c_cs) begin
      if (cnt_q[11:8] == 4'd9) begin
        w_cnt_inc[11:8] = 4'd0;
        w_c_so          = 1'b1;
      end else begin
        w_cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
      end
    end
    if (w_c_so) begin
      if (cnt_q[15:12] == 4'd5) begin
        w_cnt_inc[15:12] = 4'd0;
        w_c_st           = 1'b1;
      end else begin
        w_cnt_inc[15:12] = cnt_q[15:12] + 4'd1;
      end
    end
    if (w_c_st) begin
      if (cnt_q[19:16] == 4'd9) begin
        w_cnt_inc[19:16] = 4'd0;
        w_c_mo           = 1'b1;
      end else begin
        w_cnt_inc[19:16] = cnt_q[19:16] + 4'd1;
      end
    end
    if (w_c_mo) begin
      w_cnt_inc[23:20] = (cnt_q[23:20] == 4'd5) ? 4'd0 : cnt_q[23:20] + 4'd1;
    end
  end

  assign w_tick_ok = tick_i && (state_q == RUN || state_q == LAP);
  assign w_sat     = (cnt_q == c_CNT_MAX);

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (w_tick_ok) begin
      if (w_sat) ovf_d = 1'b1;
      else       cnt_d = w_cnt_inc;
    end
    case (state_q)
      IDLE: begin
        if (start_stop_i) state_d = RUN;
      end
      RUN: begin
        if (start_stop_i) begin
          state_d = PAUSE;
        end else if (lap_i) begin
          state_d = LAP;
          lap_d   = cnt_d;
        end
      end
      LAP: begin
        if (start_stop_i) state_d = PAUSE;
        else if (lap_i)   state_d = RUN;
      end
      PAUSE: begin
        if (clear_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          lap_d   = '0;
          ovf_d   = 1'b0;
        end else if (start_stop_i && !ovf_q) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    // A saturating tick overrides any button that arrived in the same cycle.
    if (w_tick_ok && w_sat) state_d = PAUSE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lap_q      <= '0;
      ovf_q      <= 1'b0;
      tick_en_o  <= 1'b0;
      running_o  <= 1'b0;
      frozen_o   <= 1'b0;
      disp_bcd_o <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lap_q      <= lap_d;
      ovf_q      <= ovf_d;
      tick_en_o  <= (state_d == RUN) || (state_d == LAP);
      running_o  <= (state_d == RUN) || (state_d == LAP);
      frozen_o   <= (state_d == LAP);
      disp_bcd_o <= (state_d == LAP) ? lap_d : cnt_d;
    end
  end

  assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Scoreboard bench for stopwatch_ctrl at CS_PER_SEC=100 and =2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss = 1'b0, lp = 1'b0, clr = 1'b0, tk = 1'b0;
  logic        a_te, a_run, a_frz, a_ovf, b_te, b_run, b_frz, b_ovf;
  logic [23:0] a_disp, b_disp;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CS_PER_SEC(100)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_stop_i(ss), .lap_i(lp), .clear_i(clr),
    .tick_i(tk), .tick_en_o(a_te), .running_o(a_run), .frozen_o(a_frz),
    .disp_bcd_o(a_disp), .overflow_o(a_ovf));

  // Short centisecond wrap so saturation is reachable quickly.
  stopwatch_ctrl #(.CS_PER_SEC(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_stop_i(ss), .lap_i(lp), .clear_i(clr),
    .tick_i(tk), .tick_en_o(b_te), .running_o(b_run), .frozen_o(b_frz),
    .disp_bcd_o(b_disp), .overflow_o(b_ovf));

  typedef struct {
    string       tag;
    int          sel;
    logic [23:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   t = 0;

  task automatic chk(input string tag, input logic [23:0] obs_v, input logic [23:0] exp_v);
    n_checks++;
    if (obs_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs_v, exp_v);
    end
  endtask

  function automatic logic [23:0] bcd(input int n, input int per);
    int cs, s, sec, mn;
    cs  = n % per;
    s   = n / per;
    sec = s % 60;
    mn  = s / 60;
    return {4'(mn / 10), 4'(mn % 10), 4'(sec / 10), 4'(sec % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic logic [23:0] obs(input int sel);
    case (sel)
      0:       return a_disp;
      1:       return 24'(a_te);
      2:       return 24'(a_run);
      3:       return 24'(a_frz);
      4:       return 24'(a_ovf);
      5:       return b_disp;
      6:       return 24'(b_te);
      7:       return 24'(b_run);
      8:       return 24'(b_frz);
      default: return 24'(b_ovf);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [23:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_flags(input string tag, input int base, input bit te,
                            input bit run, input bit frz, input bit ov);
    push({tag, ".tick_en"}, base + 1, 24'(te));
    push({tag, ".running"}, base + 2, 24'(run));
    push({tag, ".frozen"},  base + 3, 24'(frz));
    push({tag, ".overflow"}, base + 4, 24'(ov));
  endtask

  task automatic push_live(input string tag);
    push({tag, ".disp_a"}, 0, bcd(t, 100));
    push({tag, ".disp_b"}, 5, bcd((t > 7199) ? 7199 : t, 2));
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit s, input bit l, input bit c);
    ss = s; lp = l; clr = c;
    cyc();
    ss = 1'b0; lp = 1'b0; clr = 1'b0;
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      tk = 1'b1;
      cyc();
      tk = 1'b0;
      t++;
      repeat (gap - 1) cyc();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1);
  end

  initial begin
    repeat (2) cyc();
    push_flags("rst_a", 0, 0, 0, 0, 0);
    push_flags("rst_b", 5, 0, 0, 0, 0);
    push_live("rst");
    drain();
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // done held high while disabled must not count
    tk = 1'b1;
    repeat (5) cyc();
    tk = 1'b0;
    push_live("idle_tick");
    push_flags("idle_a", 0, 0, 0, 0, 0);
    drain();

    pulse(1, 0, 0);
    push_flags("start_a", 0, 1, 1, 0, 0);
    push_flags("start_b", 5, 1, 1, 0, 0);
    drain();

    ticks(250, 3);
    push("t250", 0, 24'h000250);
    push_live("t250");
    push("t250.run", 2, 24'd1);
    drain();

    ticks(1199 - 250, 1);
    push("b_0959", 5, 24'h095901);
    drain();
    ticks(1, 1);
    push("b_min10", 5, 24'h100000);
    push_live("t1200");
    drain();

    ticks(5999 - 1200, 1);
    push("a_005999", 0, 24'h005999);
    drain();
    ticks(1, 1);
    push("a_min1", 0, 24'h010000);
    drain();

    ticks(7199 - 6000, 1);
    push("b_max", 5, 24'h595901);
    push_flags("b_premax", 5, 1, 1, 0, 0);
    drain();
    ticks(1, 1);
    push("b_sat", 5, 24'h595901);
    push_flags("b_sat", 5, 0, 0, 0, 1);
    push("a_live", 0, 24'h011200);
    push_flags("a_live", 0, 1, 1, 0, 0);
    drain();

    pulse(1, 0, 0);
    push_flags("b_ss_ign", 5, 0, 0, 0, 1);
    push_flags("a_pause", 0, 0, 0, 0, 0);
    drain();
    pulse(0, 0, 1);
    t = 0;
    push_live("clear_sat");
    push_flags("clr_b", 5, 0, 0, 0, 0);
    drain();

    // lap freeze / unfreeze
    pulse(1, 0, 0);
    ticks(1234, 1);
    push("pre_lap", 0, 24'h001234);
    push("pre_lap_b", 5, 24'h101700);
    drain();
    pulse(0, 1, 0);
    ticks(10, 1);
    push("lap_hold", 0, 24'h001234);
    push("lap_hold_b", 5, bcd(1234, 2));
    push_flags("lap_a", 0, 1, 1, 1, 0);
    drain();
    pulse(0, 1, 0);
    push("unlap", 0, 24'h001244);
    push_flags("unlap_a", 0, 1, 1, 0, 0);
    drain();

    // lap coinciding with a counted tick captures the new count
    lp = 1'b1; tk = 1'b1;
    cyc();
    lp = 1'b0; tk = 1'b0;
    t++;
    push("lap_tick", 0, 24'h001245);
    push("lap_tick.frz", 3, 24'd1);
    drain();
    pulse(1, 0, 0);
    push_live("lap_to_pause");
    push_flags("lap_to_pause", 0, 0, 0, 0, 0);
    drain();

    // clear wins over start_stop in PAUSE
    pulse(0, 0, 1);
    t = 0;
    pulse(1, 0, 0);
    ticks(500, 1);
    pulse(1, 0, 0);
    push("pause_500", 0, 24'h000500);
    drain();
    pulse(1, 0, 1);
    t = 0;
    push_live("ss_clr");
    push_flags("ss_clr_a", 0, 0, 0, 0, 0);
    drain();

    // clear in RUN is ignored
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    push_flags("run_clr", 0, 1, 1, 0, 0);
    drain();
    ticks(37, 2);
    push("run_clr_cnt", 0, 24'h000037);
    push_live("run_clr");
    drain();

    // done held in PAUSE; lap ignored in PAUSE
    pulse(1, 0, 0);
    tk = 1'b1;
    repeat (20) cyc();
    tk = 1'b0;
    push_live("pause_hold");
    push_flags("pause_hold", 0, 0, 0, 0, 0);
    drain();
    pulse(0, 1, 0);
    push_flags("pause_lap", 0, 0, 0, 0, 0);
    drain();

    // asynchronous reset in the middle of RUN, away from any clock edge
    pulse(1, 0, 0);
    ticks(5, 1);
    push("pre_rst", 0, bcd(t, 100));
    drain();
    #3 rst_n = 1'b0;
    #1;
    t = 0;
    push_live("async_rst");
    push_flags("async_rst_a", 0, 0, 0, 0, 0);
    push_flags("async_rst_b", 5, 0, 0, 0, 0);
    drain();
    @(negedge clk) rst_n = 1'b1;
    cyc();
    cyc();
    push_flags("post_rst", 0, 0, 0, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
